fft_frame_reader: RTL

Read-side controller for the sample `fifo`. It drains the FIFO one sample at a time and accounts for the FIFO's one-cycle registered read data. It assembles `FRAME_LEN` signed samples into one packed frame and hands the frame to the 8-point FFT datapath over a valid/ready handshake. It sits between the FIFO's read port and the FFT input.

---
 rtl/fft_frame_reader.sv | 110 +++++++++++
 1 files changed

// File: rtl/fft_frame_reader.sv
// Drains the sample FIFO into FRAME_LEN-sample packed frames and hands each frame to the FFT over valid/ready.
// Optional FFT_READER_SAFE_READ_EN inserts one idle cycle after every read to tolerate the FIFO's lagging empty flag.
module fft_frame_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAME_LEN  = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             fifo_empty,
   output logic                             fifo_rd_en,
   input  logic signed [DATA_WIDTH-1:0]     fifo_data,
   output logic                             frame_valid,
   input  logic                             frame_ready,
   output logic [DATA_WIDTH*FRAME_LEN-1:0]  frame_data,
   output logic [CNT_WIDTH-1:0]             frame_cnt
);

   // Handshake: a frame transfers in any cycle where frame_valid && frame_ready;
   // frame_valid never drops and frame_data never changes until that cycle.

   localparam int CW = $clog2(FRAME_LEN) + 1;
   localparam logic [CW-1:0] LEN_C  = CW'(FRAME_LEN);
   localparam logic [CW-1:0] LAST_C = CW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      S_FILL    = 2'd0,
      S_DRAIN   = 2'd1,
      S_PRESENT = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [CW-1:0]   issue_cnt;
   logic [CW-1:0]   cap_idx;
   logic            pend;
   logic            gap;
   logic            rd_acc;
   logic            handshake;

   assign rd_acc    = fifo_rd_en && !fifo_empty;
   assign handshake = frame_valid && frame_ready;

`ifdef FFT_READER_SAFE_READ_EN
   // Idle cycle after each read so a stale !empty can never launch a read past the last entry.
   always_ff @(posedge clk) begin
      if (rst) gap <= 1'b0;
      else     gap <= rd_acc;
   end
`else
   assign gap = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FILL;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FILL: begin
            if ((rd_acc && issue_cnt == LAST_C) || issue_cnt == LEN_C) state_d = S_DRAIN;
         end
         // The last read's data arrives one cycle later; present once it is in its slot.
         S_DRAIN: begin
            if (pend && cap_idx == LAST_C) state_d = S_PRESENT;
         end
         S_PRESENT: begin
            if (handshake) state_d = S_FILL;
         end
         default: state_d = S_FILL;
      endcase
   end

   always_comb begin
      fifo_rd_en  = 1'b0;
      frame_valid = 1'b0;
      if (!rst) begin
         fifo_rd_en  = (state_q == S_FILL) && !fifo_empty && (issue_cnt < LEN_C) && !gap;
         frame_valid = (state_q == S_PRESENT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_cnt  <= '0;
         cap_idx    <= '0;
         pend       <= 1'b0;
         frame_data <= '0;
         frame_cnt  <= '0;
      end else begin
         pend <= rd_acc;
         if (handshake) begin
            issue_cnt <= '0;
            cap_idx   <= '0;
            frame_cnt <= frame_cnt + CNT_WIDTH'(1);
         end else begin
            if (rd_acc) issue_cnt <= issue_cnt + CW'(1);
            if (pend) begin
               for (int k = 0; k < FRAME_LEN; k++) begin
                  if (cap_idx == CW'(k)) frame_data[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
               end
               cap_idx <= cap_idx + CW'(1);
            end
         end
      end
   end

endmodule
